nibble_scan_mux: RTL and testbench
==================================

Name: nibble_scan_mux

Overview:
Parametrised, registered N:1 channel selector that time-multiplexes CHANNELS packed WIDTH-bit values onto one output bus. It also drives a matching active-low one-hot digit-enable vector. It sits between the datapath debug taps (PC, register values, ALU result nibbles) and the board 7-segment decoder. It supports an auto-scan mode and a manual-select mode, and adds freeze and wrap-around scanning, which the plain 2:1 select lacks.

Parameters:
- WIDTH, 4, bits per channel.
- CHANNELS, 4, number of input channels; must be ≥2.
- PRESCALE, 100000, clk cycles each channel is held in auto mode; must be ≥1.
- SEL_W, $clog2(CHANNELS), select width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_bus  input  CHANNELS*WIDTH  packed channels; channel k is in_bus[k*WIDTH +: WIDTH].
- mode  input  1  0 = auto scan, 1 = manual select.
- man_sel  input  SEL_W  channel index used in manual mode.
- freeze  input  1  1 = hold all state and outputs.
- out  output  WIDTH  registered selected channel value.
- an  output  CHANNELS  registered active-low one-hot enable; bit k low means channel k is shown.
- cur_sel  output  SEL_W  current select register.
- scan_tick  output  1  combinational pulse; high in the cycle the auto-scan select advances.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Priority per edge: reset > freeze > mode.
- Reset values: cnt=0, cur_sel=0, out=0, an=all ones (blank), scan_tick=0.
- Prescaler cnt: counts 0..PRESCALE-1.
  - It increments only when mode=0 and freeze=0.
  - At cnt==PRESCALE-1 it returns to 0.
  - In manual mode it is held at 0.
- scan_tick: equals (mode==0 && freeze==0 && cnt==PRESCALE-1). With PRESCALE=1, scan_tick stays high every non-frozen auto cycle.
- Auto mode: on scan_tick, cur_sel ← cur_sel+1, wrapping from CHANNELS-1 to 0. CHANNELS need not be a power of two; the wrap is explicit compare, not overflow.
- Manual mode: cur_sel ← man_sel every non-frozen cycle. If man_sel ≥ CHANNELS, cur_sel ← 0.
- Output register: every non-frozen cycle after reset, out ← channel[cur_sel] and an ← ~(1<<cur_sel).
  - Latency is one cycle from cur_sel or in_bus change to out.
  - in_bus is resampled continuously, so a live channel update appears one cycle later without a select change.
- Freeze: cnt, cur_sel, out and an all hold. in_bus, mode and man_sel changes are ignored. Operation resumes from the held cnt value on release.
- Mode switch 0→1: next edge loads man_sel and forces cnt=0.
- Mode switch 1→0: scanning resumes from the current cur_sel with a full PRESCALE dwell.
- Reset mid-scan: all state returns to reset values on that edge. The first edge after reset deasserts shows channel 0.
- an is always exactly one bit low after the first post-reset edge. It is never multi-hot.
- No combinational path from in_bus to out.

Test Plan:
1. Reset/start, params W=4, C=4, P=4, in_bus=16'hA3C5.
   - During reset: out=0, an=4'b1111.
   - First edge after release: out=4'h5, an=4'b1110.
   - Edge 5 after release: out=4'hC, an=4'b1101; scan_tick seen at edge 4.
2. Wrap: same setup, run 16 edges → sequence out 5,C,3,A, 4 cycles each. At edge 17, out=5 and an=1110.
3. Manual mode: mode=1.
   - man_sel=2 → out=3 two edges later.
   - man_sel=3 → out=A.
   - C=3 build with man_sel=3 → cur_sel=0, out=5.
   - cnt stays 0 and scan_tick stays 0 throughout.
4. Freeze: assert freeze mid-dwell at cnt=2, sel=1 and change in_bus to 16'hFFFF for 10 cycles → out=C, an=1101, cur_sel=1, no scan_tick. After release, sel advances after 2 more cycles.
5. Live update and reset mid-operation.
   - Change channel 1 to 4'h7 while sel=1 → out=7 next edge.
   - Assert reset while sel=3 → out=0, an=1111 on that edge.
   - Restart shows channel 0.
6. PRESCALE=1, C=3 → sel cycles 0,1,2,0 every cycle, scan_tick constantly 1, an always one-hot.

Source files
------------

// File: rtl/nibble_scan_mux.sv
// Registered N:1 channel selector for a multiplexed 7-segment display.
// Auto mode steps through the channels on a prescaled tick; manual mode follows man_sel.
module nibble_scan_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 100000,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          man_sel,
  input  logic                      freeze,
  output logic [WIDTH-1:0]          out,
  output logic [CHANNELS-1:0]       an,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      scan_tick
);

  // A one-cycle dwell still needs a 1-bit counter that simply stays at 0.
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [SEL_W-1:0]    sel_next;
  logic [WIDTH-1:0]    sel_val;
  logic [CHANNELS-1:0] onehot;
  logic                man_ok;

  always_comb begin
    sel_val = '0;
    onehot  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cur_sel == SEL_W'(k)) begin
        sel_val   = in_bus[k*WIDTH +: WIDTH];
        onehot[k] = 1'b1;
      end
    end
  end

  // Out-of-range manual indices fall back to channel 0 so an never blanks.
  assign man_ok = (int'(man_sel) < CHANNELS);

  always_comb begin
    scan_tick = !mode && !freeze && (cnt == CNT_W'(PRESCALE - 1));
    cnt_next  = cnt;
    sel_next  = cur_sel;
    if (!freeze) begin
      if (mode) begin
        cnt_next = '0;
        sel_next = man_ok ? man_sel : '0;
      end else if (scan_tick) begin
        cnt_next = '0;
        sel_next = (cur_sel == SEL_W'(CHANNELS - 1)) ? '0 : cur_sel + SEL_W'(1);
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      cur_sel <= '0;
      out     <= '0;
      an      <= '1;
    end else if (!freeze) begin
      cnt     <= cnt_next;
      cur_sel <= sel_next;
      out     <= sel_val;
      an      <= ~onehot;
    end
  end

endmodule

// File: tb/tb_nibble_scan_mux.sv
// Bench for nibble_scan_mux: a 4-channel/PRESCALE=4 instance driven from a vector
// table, and a 3-channel/PRESCALE=1 instance exercised by hand-written sequences.
module tb_nibble_scan_mux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, CHANNELS=4, PRESCALE=4
  logic        reset_a = 1'b1;
  logic [15:0] in_bus_a = 16'hA3C5;
  logic        mode_a = 1'b0;
  logic [1:0]  man_sel_a = '0;
  logic        freeze_a = 1'b0;
  logic [3:0]  out_a;
  logic [3:0]  an_a;
  logic [1:0]  cur_sel_a;
  logic        scan_tick_a;

  // Instance B: WIDTH=4, CHANNELS=3, PRESCALE=1
  logic        reset_b = 1'b1;
  logic [11:0] in_bus_b = 12'h3C5;
  logic        mode_b = 1'b0;
  logic [1:0]  man_sel_b = '0;
  logic        freeze_b = 1'b0;
  logic [3:0]  out_b;
  logic [2:0]  an_b;
  logic [1:0]  cur_sel_b;
  logic        scan_tick_b;

  nibble_scan_mux #(.WIDTH(4), .CHANNELS(4), .PRESCALE(4)) dut_a (
    .clk(clk), .reset(reset_a), .in_bus(in_bus_a), .mode(mode_a), .man_sel(man_sel_a),
    .freeze(freeze_a), .out(out_a), .an(an_a), .cur_sel(cur_sel_a), .scan_tick(scan_tick_a)
  );

  nibble_scan_mux #(.WIDTH(4), .CHANNELS(3), .PRESCALE(1)) dut_b (
    .clk(clk), .reset(reset_b), .in_bus(in_bus_b), .mode(mode_b), .man_sel(man_sel_b),
    .freeze(freeze_b), .out(out_b), .an(an_b), .cur_sel(cur_sel_b), .scan_tick(scan_tick_b)
  );

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  msel;
    logic        frz;
    logic [15:0] bus;
    int          n;       // edges to run with these inputs
    logic [3:0]  e_out;
    logic [3:0]  e_an;
    logic [1:0]  e_sel;
    int          e_ticks; // scan_tick pulses expected over those edges, -1 = unchecked
  } vec_t;

  vec_t vq[$];
  logic [17:0] exp_q[$];  // {out, an, cur_sel, ticks[7:0]}
  logic        tick_chk_q[$];
  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic mode, input logic [1:0] msel,
                     input logic frz, input logic [15:0] bus, input int n,
                     input logic [3:0] e_out, input logic [3:0] e_an,
                     input logic [1:0] e_sel, input int e_ticks);
    vec_t v;
    v = '{rst, mode, msel, frz, bus, n, e_out, e_an, e_sel, e_ticks};
    vq.push_back(v);
  endtask

  initial begin
    logic [17:0] e;
    logic        do_tick;
    logic [3:0]  ch_b[3];
    logic [2:0]  e_an_b;
    int          ticks;

    // rst mode msel frz bus n  out  an       sel ticks
    add(1, 0, 0, 0, 16'hA3C5,  2, 4'h0, 4'b1111, 0, -1); // held in reset
    add(0, 0, 0, 0, 16'hA3C5,  1, 4'h5, 4'b1110, 0,  0); // first edge: channel 0
    add(0, 0, 0, 0, 16'hA3C5,  3, 4'h5, 4'b1110, 1,  1); // tick on edge 4
    add(0, 0, 0, 0, 16'hA3C5,  1, 4'hC, 4'b1101, 1,  0); // edge 5
    add(0, 0, 0, 0, 16'hA3C5,  3, 4'hC, 4'b1101, 2,  1);
    add(0, 0, 0, 0, 16'hA3C5,  4, 4'h3, 4'b1011, 3,  1);
    add(0, 0, 0, 0, 16'hA3C5,  4, 4'hA, 4'b0111, 0,  1); // wrap 3 -> 0
    add(0, 0, 0, 0, 16'hA3C5,  1, 4'h5, 4'b1110, 0,  0); // edge 17
    add(0, 0, 0, 0, 16'hA3C5,  4, 4'hC, 4'b1101, 1,  1);
    add(0, 0, 0, 0, 16'hA3C5,  1, 4'hC, 4'b1101, 1,  0); // cnt=2, sel=1
    add(0, 0, 0, 1, 16'hFFFF, 10, 4'hC, 4'b1101, 1,  0); // frozen
    add(0, 0, 0, 0, 16'hA3C5,  1, 4'hC, 4'b1101, 1,  0); // resume cnt 2->3
    add(0, 0, 0, 0, 16'hA3C5,  1, 4'hC, 4'b1101, 2,  1); // advance 2 edges after release
    add(0, 0, 0, 0, 16'hA3C5,  1, 4'h3, 4'b1011, 2,  0);
    add(0, 1, 1, 0, 16'hA3C5,  1, 4'h3, 4'b1011, 1,  0); // manual load
    add(0, 1, 1, 0, 16'hA3C5,  1, 4'hC, 4'b1101, 1,  0);
    add(0, 1, 2, 0, 16'hA3C5,  2, 4'h3, 4'b1011, 2,  0);
    add(0, 1, 3, 0, 16'hA3C5,  2, 4'hA, 4'b0111, 3,  0);
    add(0, 1, 3, 0, 16'hA3C5, 10, 4'hA, 4'b0111, 3,  0); // no ticks in manual
    add(0, 1, 1, 0, 16'hA3C5,  2, 4'hC, 4'b1101, 1,  0);
    add(0, 1, 1, 0, 16'hA375,  1, 4'h7, 4'b1101, 1,  0); // live channel update
    add(0, 0, 0, 0, 16'hA375,  3, 4'h7, 4'b1101, 1,  0); // back to auto: full dwell
    add(0, 0, 0, 0, 16'hA375,  1, 4'h7, 4'b1101, 2,  1);
    add(0, 0, 0, 0, 16'hA375,  4, 4'h3, 4'b1011, 3,  1);
    add(1, 0, 0, 0, 16'hA375,  1, 4'h0, 4'b1111, 0,  0); // reset mid-scan
    add(0, 0, 0, 0, 16'hA375,  1, 4'h5, 4'b1110, 0,  0); // restart on channel 0

    foreach (vq[i]) begin
      reset_a   = vq[i].rst;
      mode_a    = vq[i].mode;
      man_sel_a = vq[i].msel;
      freeze_a  = vq[i].frz;
      in_bus_a  = vq[i].bus;
      exp_q.push_back({vq[i].e_out, vq[i].e_an, vq[i].e_sel, 8'(vq[i].e_ticks)});
      tick_chk_q.push_back(vq[i].e_ticks >= 0);
      ticks = 0;
      repeat (vq[i].n) begin
        @(negedge clk);
        if (scan_tick_a === 1'b1) ticks++;
        @(posedge clk);
        #1;
      end
      e = exp_q.pop_front();
      do_tick = tick_chk_q.pop_front();
      check("a_out", i, 32'(out_a), 32'(e[17:14]));
      check("a_an", i, 32'(an_a), 32'(e[13:10]));
      check("a_sel", i, 32'(cur_sel_a), 32'(e[9:8]));
      if (do_tick) check("a_ticks", i, ticks, 32'(e[7:0]));
    end

    // Instance B: PRESCALE=1 means a tick on every unfrozen auto cycle.
    ch_b = '{4'h5, 4'hC, 4'h3};
    check("b_reset_out", 0, 32'(out_b), 32'h0);
    check("b_reset_an", 0, 32'(an_b), 32'b111);
    reset_b = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e_an_b = ~(3'b001 << (i % 3));
      exp_q.push_back({ch_b[i % 3], 1'b0, e_an_b, 2'((i + 1) % 3), 8'h0});
      @(negedge clk);
      check("b_tick", i, 32'(scan_tick_b), 32'h1);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("b_out", i, 32'(out_b), 32'(e[17:14]));
      check("b_an", i, 32'(an_b), 32'(e[12:10]));
      check("b_sel", i, 32'(cur_sel_b), 32'(e[9:8]));
      check("b_onehot", i, $countones(~an_b), 1);
    end

    // Manual index beyond the channel count falls back to channel 0.
    mode_b = 1'b1;
    man_sel_b = 2'd3;
    exp_q.push_back({4'h5, 1'b0, 3'b110, 2'd0, 8'h0});
    repeat (2) begin
      @(negedge clk);
      check("b_man_tick", 0, 32'(scan_tick_b), 32'h0);
      @(posedge clk);
      #1;
    end
    e = exp_q.pop_front();
    check("b_man_sel", 0, 32'(cur_sel_b), 32'(e[9:8]));
    check("b_man_out", 0, 32'(out_b), 32'(e[17:14]));
    check("b_man_an", 0, 32'(an_b), 32'(e[12:10]));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
